// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks every N_IN-bit input vector of a combinational
// unit under test in binary order, holds each one for SETTLE cycles, then
// compares the unit's response against the golden model. It accumulates the
// mismatch count and the lowest failing vector.
// Optional build macro SWEEP_SIGNATURE_EN adds sig_o, a 16-bit CRC-style
// fingerprint of the whole response table.
module truth_table_sweeper #(
    parameter int N_IN   = 3,
    parameter int N_OUT  = 1,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   stim_o,
    input  logic [N_OUT-1:0]  resp_i,
    input  logic [N_OUT-1:0]  exp_i,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic [N_IN-1:0]   first_fail_vec,
    output logic              first_fail_valid
`ifdef SWEEP_SIGNATURE_EN
    ,
    output logic [15:0]       sig_o
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_APPLY, S_SAMPLE, S_DONE} state_t;

    localparam logic [N_IN-1:0] LAST_VEC    = '1;
    localparam logic [N_IN-1:0] VEC_ONE     = N_IN'(1);
    localparam logic [N_IN:0]   ERR_ONE     = (N_IN+1)'(1);
    localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE - 1);

    state_t     state, next_state;
    logic [7:0] settle_cnt;
    logic       launch;
    logic       mismatch;
    logic       stay_done;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next-state logic; launch marks an accepted start (only in IDLE/DONE)
    always_comb begin
        next_state = state;
        launch     = 1'b0;
        case (state)
            S_IDLE:   if (start) begin launch = 1'b1; next_state = S_APPLY; end
            S_APPLY:  if (settle_cnt == SETTLE_LAST) next_state = S_SAMPLE;
            S_SAMPLE: next_state = (stim_o == LAST_VEC) ? S_DONE : S_APPLY;
            S_DONE:   if (start) begin launch = 1'b1; next_state = S_APPLY; end
            default:  next_state = S_IDLE;
        endcase
    end

    // Response compare; an unknown compare result falls to the mismatch side
    always_comb begin
        mismatch = 1'b1;
        if (resp_i == exp_i) mismatch = 1'b0;
    end

    // done/pass assert one cycle after entering DONE and drop on a restart
    assign stay_done = (state == S_DONE) && (next_state == S_DONE);

`ifdef SWEEP_SIGNATURE_EN
    localparam int N_CHUNK = (N_OUT + 15) / 16;

    logic [N_CHUNK*16-1:0] resp_pad;
    logic [15:0]           resp_fold;
    logic [15:0]           sig_next;

    // Fold the response into 16 bits (XOR of zero-padded chunks) and advance
    // the CCITT-polynomial shift register by one step
    always_comb begin
        resp_pad              = '0;
        resp_pad[N_OUT-1:0]   = resp_i;
        resp_fold             = '0;
        for (int c = 0; c < N_CHUNK; c++)
            resp_fold = resp_fold ^ resp_pad[c*16 +: 16];
        sig_next = {sig_o[14:0], 1'b0} ^ (sig_o[15] ? 16'h1021 : 16'h0000) ^ resp_fold;
    end

    // Signature register: re-seeded on every sweep launch
    always_ff @(posedge clk) begin
        if (rst)                      sig_o <= 16'hFFFF;
        else if (launch)              sig_o <= 16'hFFFF;
        else if (state == S_SAMPLE)   sig_o <= sig_next;
    end
`endif

    // Datapath: stimulus, settle counter, result accumulation and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            stim_o           <= '0;
            settle_cnt       <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            busy <= (next_state == S_APPLY) || (next_state == S_SAMPLE) ||
                    ((next_state == S_DONE) && (state != S_DONE));
            done <= stay_done;
            pass <= stay_done && (err_count == '0);
            if (launch) begin
                stim_o           <= '0;
                settle_cnt       <= '0;
                err_count        <= '0;
                first_fail_vec   <= '0;
                first_fail_valid <= 1'b0;
            end else begin
                case (state)
                    S_APPLY: begin
                        if (settle_cnt == SETTLE_LAST) settle_cnt <= '0;
                        else                           settle_cnt <= settle_cnt + 8'd1;
                    end
                    S_SAMPLE: begin
                        if (mismatch) begin
                            err_count <= err_count + ERR_ONE;
                            if (!first_fail_valid) begin
                                first_fail_vec   <= stim_o;
                                first_fail_valid <= 1'b1;
                            end
                        end
                        // Final vector exits to DONE, so stim_o never wraps
                        if (stim_o != LAST_VEC) stim_o <= stim_o + VEC_ONE;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
